// File: rtl/mips_prog_loader.sv
// mips_prog_loader: byte-stream instruction loader for pipe_MIPS32.
// Accepts LEN_HI, LEN_LO (word count N) and then 4*N payload bytes, MSB first.
// Each assembled big-endian word is written to instruction memory at BASE_ADDR+index.
// The core is held while the load runs and is then released with a one-cycle start pulse.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, one checksum byte
// follows the payload. It must equal the XOR of all payload bytes, or the load is rejected.
module mips_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_START  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       words_q, words_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    // Output decode: handshake, hold and status depend only on the current state.
    always_comb begin
        in_ready     = (state_q == S_IDLE) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
        cpu_hold     = !((state_q == S_START) || (state_q == S_DONE));
        cpu_start    = (state_q == S_START);
        load_done    = (state_q == S_DONE);
        load_err     = (state_q == S_ERR);
        mem_we       = we_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        words_loaded = words_q;
    end

    // Next-state logic: length parse, word assembly, write generation and the release sequence.
    // When in_ready is high, in_valid alone marks a transfer.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    len_d   = {in_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (in_valid) begin
                    len_d = {len_q[15:8], in_data};
                    if ((len_d == 16'd0) || ({16'd0, len_d} > 32'(MAX_WORDS)))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    asm_d  = {asm_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d  = chk_q ^ in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {asm_q, in_data};
                        addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(words_q);
                        words_d = words_q + 16'd1;
                        if (words_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_FLUSH;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (in_valid)
                    state_d = (in_data == chk_q) ? S_START : S_ERR;
            end
`endif
            // FLUSH keeps in_ready low for a cycle so the last write lands before release.
            S_FLUSH: state_d = S_START;
            S_START: state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    // Control and output registers, all returned to their reset values on reset.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            bcnt_q  <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= 32'd0;
            words_q <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            words_q <= words_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // The byte assembler needs no reset: the byte counter decides when its contents are used.
    always_ff @(posedge clk1) begin
        asm_q <= asm_d;
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Testbench for mips_prog_loader.
// Two loaders share one byte stream: one has BASE_ADDR=0 and the other BASE_ADDR=1022.
// Observed writes and status are compared with a stream-level reference model.
module tb_mips_prog_loader;

    localparam int NDUT = 2;
    localparam int MAXW = 1024;
    localparam int LOGN = 2048;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];

    int base_of [NDUT] = '{0, 1022};

    logic        clk1     = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready     [NDUT];
    logic        mem_we       [NDUT];
    logic [9:0]  mem_addr     [NDUT];
    logic [31:0] mem_wdata    [NDUT];
    logic        cpu_hold     [NDUT];
    logic        cpu_start    [NDUT];
    logic        load_done    [NDUT];
    logic        load_err     [NDUT];
    logic [15:0] words_loaded [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    mips_prog_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(MAXW)) dut0 (
        .clk1(clk1), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .cpu_hold(cpu_hold[0]), .cpu_start(cpu_start[0]),
        .load_done(load_done[0]), .load_err(load_err[0]), .words_loaded(words_loaded[0])
    );

    mips_prog_loader #(.ADDR_W(10), .BASE_ADDR(1022), .MAX_WORDS(MAXW)) dut1 (
        .clk1(clk1), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .cpu_hold(cpu_hold[1]), .cpu_start(cpu_start[1]),
        .load_done(load_done[1]), .load_err(load_err[1]), .words_loaded(words_loaded[1])
    );

    // Event monitor: these counters only ever grow; the main process works with differences.
    logic [41:0] wr_log    [NDUT][LOGN];
    int          wr_cnt    [NDUT] = '{default: 0};
    int          dbl_we    [NDUT] = '{default: 0};
    int          start_cnt [NDUT] = '{default: 0};
    int          start_cyc [NDUT] = '{default: 0};
    int          start_bad [NDUT] = '{default: 0};
    int          hold_rise [NDUT] = '{default: 0};
    int          done_cyc  [NDUT] = '{default: 0};
    logic        prev_we   [NDUT] = '{default: 1'b0};
    logic        prev_hold [NDUT] = '{default: 1'b1};
    logic        prev_done [NDUT] = '{default: 1'b0};

    always @(negedge clk1) begin
        for (int d = 0; d < NDUT; d++) begin
            prev_we[d]   <= mem_we[d];
            prev_hold[d] <= cpu_hold[d];
            prev_done[d] <= load_done[d];
            if (!reset) begin
                if (mem_we[d]) begin
                    if (wr_cnt[d] < LOGN) wr_log[d][wr_cnt[d]] <= {mem_addr[d], mem_wdata[d]};
                    wr_cnt[d] <= wr_cnt[d] + 1;
                    if (prev_we[d]) dbl_we[d] <= dbl_we[d] + 1;
                end
                if (cpu_start[d]) begin
                    start_cnt[d] <= start_cnt[d] + 1;
                    start_cyc[d] <= cyc;
                    if (cpu_hold[d]) start_bad[d] <= start_bad[d] + 1;
                end
                if (cpu_hold[d] && !prev_hold[d]) hold_rise[d] <= hold_rise[d] + 1;
                if (load_done[d] && !prev_done[d]) done_cyc[d] <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clk1);
        #1 reset = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_ready%0d", d), in_ready[d], 1);
            check($sformatf("rst_hold%0d", d), cpu_hold[d], 1);
            check($sformatf("rst_flags%0d", d),
                  {mem_we[d], cpu_start[d], load_done[d], load_err[d]}, 0);
            check($sformatf("rst_addr%0d", d), mem_addr[d], base_of[d]);
            check($sformatf("rst_wdata%0d", d), mem_wdata[d], 0);
            check($sformatf("rst_words%0d", d), words_loaded[d], 0);
        end
    endtask

    // Drive one byte after an optional idle gap, and hold it until the loader takes it.
    task automatic push(input logic [7:0] b, input int maxgap);
        int g;
        int t;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        t = 0;
        repeat (g) begin
            in_valid = 1'b0;
            @(posedge clk1);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready[0] && t < 20) begin
            @(posedge clk1);
            #1;
            t++;
        end
        if (!in_ready[0]) check("ready_timeout", in_ready[0], 1);
        @(posedge clk1);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    // Build a well-formed stream from a word list, with a good or bad checksum when enabled.
    function automatic bq_t mk_stream(input wq_t w, input bit bad_chk);
        bq_t s;
        logic [7:0] x;
        x = 8'h00;
        s.push_back(8'(w.size() >> 8));
        s.push_back(8'(w.size()));
        foreach (w[i]) begin
            for (int k = 3; k >= 0; k--) begin
                s.push_back(w[i][8*k +: 8]);
                x ^= w[i][8*k +: 8];
            end
        end
        if (CHK_EN) s.push_back(bad_chk ? ~x : x);
        return s;
    endfunction

    // Reference model: what a loader must do with a complete stream.
    logic [31:0] exp_words[$];
    bit          exp_done;
    bit          exp_err;

    task automatic model(input bq_t s);
        int n;
        logic [7:0] x;
        exp_words.delete();
        n = {s[0], s[1]};
        x = 8'h00;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n == 0 || n > MAXW) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_words.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
                for (int k = 0; k < 4; k++) x ^= s[2+4*i+k];
            end
            if (CHK_EN) begin
                exp_done = (s[2+4*n] == x);
                exp_err  = !exp_done;
            end else begin
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic run(input string name, input bq_t s, input int maxgap);
        int w0 [NDUT];
        int st0 [NDUT];
        int db0 [NDUT];
        int hr0 [NDUT];
        int sb0 [NDUT];
        do_reset();
        for (int d = 0; d < NDUT; d++) begin
            w0[d] = wr_cnt[d]; st0[d] = start_cnt[d]; db0[d] = dbl_we[d];
            hr0[d] = hold_rise[d]; sb0[d] = start_bad[d];
        end
        model(s);
        foreach (s[i]) push(s[i], maxgap);
        repeat (12) @(posedge clk1);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s/nwr%0d", name, d), wr_cnt[d] - w0[d], exp_words.size());
            foreach (exp_words[i]) begin
                if (w0[d] + i < wr_cnt[d] && w0[d] + i < LOGN) begin
                    check($sformatf("%s/addr%0d[%0d]", name, d, i),
                          wr_log[d][w0[d]+i][41:32], (base_of[d] + i) % 1024);
                    check($sformatf("%s/data%0d[%0d]", name, d, i),
                          wr_log[d][w0[d]+i][31:0], exp_words[i]);
                end
            end
            check($sformatf("%s/words%0d", name, d), words_loaded[d], exp_words.size());
            check($sformatf("%s/done%0d", name, d), load_done[d], exp_done);
            check($sformatf("%s/err%0d", name, d), load_err[d], exp_err);
            check($sformatf("%s/hold%0d", name, d), cpu_hold[d], !exp_done);
            check($sformatf("%s/nstart%0d", name, d), start_cnt[d] - st0[d], exp_done ? 1 : 0);
            check($sformatf("%s/dblwe%0d", name, d), dbl_we[d] - db0[d], 0);
            check($sformatf("%s/holdrise%0d", name, d), hold_rise[d] - hr0[d], 0);
            check($sformatf("%s/starthold%0d", name, d), start_bad[d] - sb0[d], 0);
            if (exp_done) begin
                check($sformatf("%s/tstart%0d", name, d), start_cyc[d], last_acc + (CHK_EN ? 0 : 1));
                check($sformatf("%s/tdone%0d", name, d), done_cyc[d], start_cyc[d] + 1);
            end
        end
    endtask

    initial begin
        wq_t img;
        wq_t w;
        bq_t s;
        int w0;

        img = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        run("nine_b2b", mk_stream(img, 1'b0), 0);
        run("nine_gaps", mk_stream(img, 1'b0), 5);

        s = '{8'h00, 8'h00};
        run("len0", s, 0);
        s = '{8'h04, 8'h01};
        run("len1025", s, 2);

        w = '{32'h00000001, 32'h00000002};
        run("two_good", mk_stream(w, 1'b0), 1);
        if (CHK_EN) begin
            s = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00};
            run("two_badchk", s, 1);
        end

        // Abort a 3-word load after 6 payload bytes, then load 2 words cleanly.
        do_reset();
        w0 = wr_cnt[0];
        s = '{8'h00, 8'h03, 8'hde, 8'had, 8'hbe, 8'hef, 8'h12, 8'h34};
        foreach (s[i]) push(s[i], 1);
        repeat (3) @(posedge clk1);
        #1;
        check("abort/nwr", wr_cnt[0] - w0, 1);
        check("abort/word", wr_log[0][w0], {10'd0, 32'hdeadbeef});
        check("abort/words", words_loaded[0], 1);
        check("abort/hold", cpu_hold[0], 1);
        w = '{32'hcafef00d, 32'h01234567};
        run("after_abort", mk_stream(w, 1'b0), 0);

        // Three words: the second loader wraps from 1023 back to 0.
        w = '{32'h11111111, 32'h22222222, 32'h33333333};
        run("wrap3", mk_stream(w, 1'b0), 0);

        for (int r = 0; r < 5; r++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(8, 1)); i++) w.push_back($urandom);
            run($sformatf("rand%0d", r), mk_stream(w, ($urandom_range(2, 0) == 0)), 3);
        end

        w.delete();
        for (int i = 0; i < MAXW; i++) w.push_back($urandom);
        run("max_len", mk_stream(w, 1'b0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
